// File: rtl/coax_buffered_tx_if.sv
// rtl/coax_buffered_tx_if.sv - handshake/line bundle for the buffered coax transmitter
// Purpose: groups the word-load, start and line/status signals of coax_buffered_tx.
// Signals:
//   data[9:0]    word to enqueue
//   load_strobe  one-cycle pulse, enqueue data
//   start_strobe one-cycle pulse, begin a transmission
//   tx           biphase-encoded line output
//   active       line-driver enable, high during a transmission
//   full/empty   FIFO occupancy flags
//   error        sticky overflow flag
// Modports: master drives data/strobes, slave (the transmitter) drives line/status.
interface coax_buffered_tx_if;
  logic [9:0] data;
  logic       load_strobe;
  logic       start_strobe;
  logic       tx;
  logic       active;
  logic       full;
  logic       empty;
  logic       error;

  modport master (
    output data, load_strobe, start_strobe,
    input  tx, active, full, empty, error
  );

  modport slave (
    input  data, load_strobe, start_strobe,
    output tx, active, full, empty, error
  );
endinterface

// File: rtl/coax_buffered_tx.sv
// rtl/coax_buffered_tx.sv - FIFO-buffered biphase coax word transmitter
// Purpose: queues 10-bit words and sends them as a biphase frame:
//   quiesce (five 1s), code violation, then per word sync/10 data/parity,
//   then an end bit and a mini code violation.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high
//   bus    coax_buffered_tx_if.slave (data, load_strobe, start_strobe in;
//          tx, active, full, empty, error out)
module coax_buffered_tx #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int DEPTH          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  coax_buffered_tx_if.slave    bus
);

  localparam int HALF = CLOCKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLOCKS_PER_BIT);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE, LINE_QUIESCE, CODE_VIOLATION, SYNC_BIT,
    DATA_BITS, PARITY_BIT, END_BIT, MINI_CODE_VIOLATION
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      shift_q, shift_d;
  logic            parity_q, parity_d;

  logic [9:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            error_q, error_d;

  logic full, empty, push, pop;
  logic cell_end, second_half, enter_sync, tx_o;

  assign full        = (count_q == (AW+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign cell_end    = (clk_cnt_q == CW'(CLOCKS_PER_BIT - 1));
  assign second_half = (clk_cnt_q >= CW'(HALF));

  // A pop in the same cycle frees a slot, so a load on a full FIFO still lands.
  assign push = bus.load_strobe && (!full || pop);

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = '0;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    enter_sync = 1'b0;
    pop        = 1'b0;
    tx_o       = 1'b0;

    if (state_q != IDLE)
      clk_cnt_d = cell_end ? '0 : clk_cnt_q + CW'(1);

    // Biphase: the bit value in the first half, its complement in the second.
    case (state_q)
      IDLE: begin
        if (bus.start_strobe && !empty) begin
          state_d   = LINE_QUIESCE;
          bit_cnt_d = '0;
        end
      end
      LINE_QUIESCE: begin
        tx_o = ~second_half;
        if (cell_end) begin
          if (bit_cnt_q == 4'd4) begin
            state_d   = CODE_VIOLATION;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      CODE_VIOLATION: begin
        // Three half-cells high then three low spans three bit cells.
        tx_o = (bit_cnt_q == 4'd0) || (bit_cnt_q == 4'd1 && !second_half);
        if (cell_end) begin
          if (bit_cnt_q == 4'd2) enter_sync = 1'b1;
          else                   bit_cnt_d  = bit_cnt_q + 4'd1;
        end
      end
      SYNC_BIT: begin
        tx_o = ~second_half;
        if (cell_end) begin
          state_d   = DATA_BITS;
          bit_cnt_d = '0;
        end
      end
      DATA_BITS: begin
        tx_o = shift_q[9] ^ second_half;
        if (cell_end) begin
          shift_d = {shift_q[8:0], 1'b0};
          if (bit_cnt_q == 4'd9) state_d   = PARITY_BIT;
          else                   bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      PARITY_BIT: begin
        tx_o = parity_q ^ second_half;
        if (cell_end) begin
          if (!empty) enter_sync = 1'b1;
          else        state_d    = END_BIT;
        end
      end
      END_BIT: begin
        tx_o = second_half;
        if (cell_end) state_d = MINI_CODE_VIOLATION;
      end
      MINI_CODE_VIOLATION: begin
        tx_o = 1'b1;
        if (cell_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Word is taken from the FIFO as SYNC_BIT is entered; parity makes the
    // sync+data+parity ones count even.
    if (enter_sync) begin
      state_d   = SYNC_BIT;
      bit_cnt_d = '0;
      pop       = 1'b1;
      shift_d   = mem_q[rd_ptr_q];
      parity_d  = ~(^mem_q[rd_ptr_q]);
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
    error_d  = error_q | (bus.load_strobe && full && !pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      error_q   <= error_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data;
  end

  assign bus.tx     = tx_o;
  assign bus.active = (state_q != IDLE);
  assign bus.full   = full;
  assign bus.empty  = empty;
  assign bus.error  = error_q;

endmodule

// File: tb/tb_coax_buffered_tx.sv
// tb/tb_coax_buffered_tx.sv - directed self-checking bench for coax_buffered_tx
module tb_coax_buffered_tx;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  coax_buffered_tx_if bus ();

  coax_buffered_tx #(.CLOCKS_PER_BIT(8), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic       txs [0:2047];
  int         n_act;
  logic [9:0] dec_data [0:15];
  logic       dec_par  [0:15];
  int         bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [9:0] v);
    bus.data = v;
    bus.load_strobe = 1'b1;
    @(negedge clk);
    bus.load_strobe = 1'b0;
  endtask

  // Pulses start and records tx every cycle while active; optionally loads
  // a word at a given cycle offset into the transmission.
  task automatic run(input int load_at, input logic [9:0] load_val);
    bus.start_strobe = 1'b1;
    @(negedge clk);
    bus.start_strobe = 1'b0;
    n_act = 0;
    while (bus.active === 1'b1 && n_act < 2000) begin
      txs[n_act] = bus.tx;
      if (n_act == load_at) begin
        bus.data = load_val;
        bus.load_strobe = 1'b1;
      end else begin
        bus.load_strobe = 1'b0;
      end
      n_act++;
      @(negedge clk);
    end
    bus.load_strobe = 1'b0;
    if (n_act >= 2000) chk("active_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic h1(input int c); return txs[c*8 + 1]; endfunction
  function automatic logic h2(input int c); return txs[c*8 + 5]; endfunction

  // Decode nw words from the recorded line and count framing errors.
  task automatic decode(input int nw);
    int b;
    bad = 0;
    for (int c = 0; c < 5; c++) if (!(h1(c) == 1 && h2(c) == 0)) bad++;
    if (!(h1(5) == 1 && h2(5) == 1)) bad++;
    if (!(h1(6) == 1 && h2(6) == 0)) bad++;
    if (!(h1(7) == 0 && h2(7) == 0)) bad++;
    for (int w = 0; w < nw; w++) begin
      b = 8 + 12*w;
      if (!(h1(b) == 1 && h2(b) == 0)) bad++;
      for (int k = 1; k <= 11; k++) if (h1(b+k) == h2(b+k)) bad++;
      for (int k = 0; k < 10; k++) dec_data[w][9-k] = h1(b+1+k);
      dec_par[w] = h1(b+11);
    end
    b = 8 + 12*nw;
    if (!(h1(b) == 0 && h2(b) == 1)) bad++;
    if (!(h1(b+1) == 1 && h2(b+1) == 1)) bad++;
  endtask

  initial begin
    int quiet_bad;
    logic [9:0] exp4 [0:3];
    logic       par4 [0:3];
    exp4 = '{10'h001, 10'h002, 10'h003, 10'h004};
    par4 = '{1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    bus.data = '0;
    bus.load_strobe = 1'b0;
    bus.start_strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_tx", bus.tx, 0);
    chk("rst_active", bus.active, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_error", bus.error, 0);

    // Start with an empty FIFO must be ignored.
    bus.start_strobe = 1'b1;
    @(negedge clk);
    bus.start_strobe = 1'b0;
    quiet_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.active !== 1'b0 || bus.tx !== 1'b0) quiet_bad++;
      @(negedge clk);
    end
    chk("empty_start_quiet", quiet_bad, 0);

    // Single word.
    load(10'h001);
    chk("one_empty_after_load", bus.empty, 0);
    run(-1, 10'h0);
    chk("one_active_len", n_act, 176);
    decode(1);
    chk("one_frame", bad, 0);
    chk("one_data", dec_data[0], 10'h001);
    chk("one_parity", dec_par[0], 0);
    chk("one_empty_end", bus.empty, 1);
    chk("one_tx_idle", bus.tx, 0);

    // Four words in order.
    for (int i = 0; i < 4; i++) load(exp4[i]);
    run(-1, 10'h0);
    chk("four_active_len", n_act, 464);
    decode(4);
    chk("four_frame", bad, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("four_data%0d", i), dec_data[i], exp4[i]);
      chk($sformatf("four_par%0d", i), dec_par[i], par4[i]);
    end

    // Overflow: nine loads into eight slots.
    for (int i = 0; i < 8; i++) load(10'h100 + 10'(i));
    chk("ovf_full8", bus.full, 1);
    chk("ovf_err8", bus.error, 0);
    load(10'h2AA);
    chk("ovf_err9", bus.error, 1);
    chk("ovf_full9", bus.full, 1);
    run(-1, 10'h0);
    chk("ovf_active_len", n_act, 848);
    decode(8);
    chk("ovf_frame", bad, 0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("ovf_data%0d", i), dec_data[i], 10'h100 + 10'(i));
    chk("ovf_err_sticky", bus.error, 1);
    chk("ovf_empty_end", bus.empty, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("ovf_err_cleared", bus.error, 0);

    // Load during DATA_BITS of the first word chains a second word.
    load(10'h3FF);
    run(100, 10'h000);
    chk("chain_active_len", n_act, 272);
    decode(2);
    chk("chain_frame", bad, 0);
    chk("chain_data0", dec_data[0], 10'h3FF);
    chk("chain_par0", dec_par[0], 1);
    chk("chain_data1", dec_data[1], 10'h000);
    chk("chain_par1", dec_par[1], 1);

    // Reset mid-DATA_BITS aborts the frame.
    load(10'h155);
    bus.start_strobe = 1'b1;
    @(negedge clk);
    bus.start_strobe = 1'b0;
    repeat (80) @(negedge clk);
    chk("abort_active_before", bus.active, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_tx", bus.tx, 0);
    chk("abort_active", bus.active, 0);
    chk("abort_empty", bus.empty, 1);
    chk("abort_error", bus.error, 0);
    quiet_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.active !== 1'b0 || bus.tx !== 1'b0) quiet_bad++;
    end
    chk("abort_quiet", quiet_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/coax_buffered_tx.md
COAX_BUFFERED_TX -- requirements
Module: coax_buffered_tx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 8, clocks per bit cell; even, >= 4.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO capacity in 10-bit words; power of two.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data  input  10  word to enqueue.
REQ-006 SHALL have port load_strobe  input  1  one-cycle pulse; enqueue data.
REQ-007 SHALL have port start_strobe  input  1  one-cycle pulse; begin a transmission.
REQ-008 SHALL have port tx  output  1  biphase-encoded line output.
REQ-009 SHALL have port active  output  1  high while a transmission is on the line; line-driver enable.
REQ-010 SHALL have port full  output  1  FIFO holds DEPTH words.
REQ-011 SHALL have port empty  output  1  FIFO holds zero words.
REQ-012 SHALL have port error  output  1  sticky overflow flag.

Function
REQ-013 SHALL encode each bit cell as two halves of CLOCKS_PER_BIT/2 clocks: 1 = high then low; 0 = low then high.
REQ-014 SHALL hold tx low and active low in IDLE.
REQ-015 SHALL write data into the FIFO on a load_strobe cycle when not full; full/empty update on the next cycle.
REQ-016 SHALL drop the word on a load_strobe cycle when full and set error on the next cycle; error stays set until reset.
REQ-017 SHALL accept loads at any time, including mid-transmission; a word loaded before the current parity bit ends is sent in the same transmission.
REQ-018 SHALL ignore start_strobe when active is high or empty is high.
REQ-019 SHALL, on an accepted start_strobe in cycle N, assert active and begin LINE_QUIESCE in cycle N+1.
REQ-020 SHALL sequence the states IDLE -> LINE_QUIESCE (five 1 bits) -> CODE_VIOLATION -> SYNC_BIT -> DATA_BITS -> PARITY_BIT -> {SYNC_BIT | END_BIT} -> MINI_CODE_VIOLATION -> IDLE.
REQ-021 SHALL drive CODE_VIOLATION as 3 half-cells high, then 3 half-cells low.
REQ-022 SHALL pop one FIFO word on entry to SYNC_BIT, then send a sync bit of 1.
REQ-023 SHALL send the 10 data bits MSB first.
REQ-024 SHALL send a parity bit equal to the inverted XOR of the 10 data bits, so sync, data and parity together hold an even count of ones.
REQ-025 SHALL, after PARITY_BIT, go to SYNC_BIT if the FIFO is non-empty, otherwise to END_BIT.
REQ-026 SHALL send END_BIT as a 0 bit, then drive MINI_CODE_VIOLATION as tx high for CLOCKS_PER_BIT clocks.
REQ-027 SHALL, after MINI_CODE_VIOLATION, return to IDLE with tx low and active low.
REQ-028 SHALL keep active high for exactly (10 + 12*W) * CLOCKS_PER_BIT clocks for W words sent.
REQ-029 SHALL, when load_strobe and an internal pop fall in the same cycle with the FIFO full, perform both; no overflow, count unchanged.
REQ-030 SHALL wrap FIFO read and write pointers modulo DEPTH.

Reset
REQ-031 SHALL, on reset, within one cycle: state IDLE, FIFO cleared, tx=0, active=0, full=0, empty=1, error=0.
REQ-032 SHALL let reset abort a transmission in progress; the line drops idle the next cycle and no further bits are sent.

Verification
REQ-033 SHALL cover: with CLOCKS_PER_BIT=8, load 0x001, then start -> active high for 176 clocks; decoded data 0x001, parity 0; empty=1 at end.
REQ-034 SHALL cover: load 0x001, 0x002, 0x003, 0x004, then start -> four words decoded in order with parity 0,0,1,0; active high for 464 clocks.
REQ-035 SHALL cover: 9 loads with DEPTH=8, no start -> full=1 after the 8th load; error=1 after the 9th; the 9th word is absent from a later transmission.
REQ-036 SHALL cover: start_strobe with FIFO empty -> active stays 0 and tx stays 0.
REQ-037 SHALL cover: load 0x3FF, start, then load 0x000 during DATA_BITS of the first word -> two words sent, parity 1 then 1; 0x000 follows with no intervening end sequence.
REQ-038 SHALL cover: reset asserted mid-DATA_BITS -> next cycle tx=0, active=0, empty=1, error=0.
